// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: decodes AA/BB/CC/DD byte frames from UART RX into RF/ALU operations, returns
// results to the TX FIFO. Define CMD_TIMEOUT_EN to abandon a stalled command after TIMEOUT_CYC cycles.

module sys_cmd_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned FUN_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                ref_clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   rx_p_data,
  input  logic                rx_d_valid,
  input  logic [DATA_W-1:0]   rf_rd_data,
  input  logic                rf_rd_valid,
  input  logic [2*DATA_W-1:0] alu_out,
  input  logic                alu_out_valid,
  input  logic                tx_full,
  output logic                rf_wr_en,
  output logic                rf_rd_en,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_wr_data,
  output logic                alu_en,
  output logic [FUN_W-1:0]    alu_fun,
  output logic                alu_clk_en,
  output logic                tx_wr_en,
  output logic [DATA_W-1:0]   tx_wr_data
);

  localparam logic [DATA_W-1:0] CmdWr  = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] CmdRd  = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] CmdAlu = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] CmdFun = DATA_W'(8'hDD);

  typedef enum logic [3:0] {
    StIdle, StWrAddr, StWrData, StRdAddr, StRdWait, StOpA, StOpB, StFun, StAluWait, StTxLo, StTxHi
  } state_e;

  state_e              state_q, state_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                alu_path_q, alu_path_d;
  logic                timeout;

  logic                rf_wr_en_d, rf_rd_en_d, alu_en_d, alu_clk_en_d, tx_wr_en_d;
  logic [ADDR_W-1:0]   rf_addr_d;
  logic [DATA_W-1:0]   rf_wr_data_d, tx_wr_data_d;
  logic [FUN_W-1:0]    alu_fun_d;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q;
  logic            byte_state;

  always_comb begin
    byte_state = state_q inside {StWrAddr, StWrData, StRdAddr, StOpA, StOpB, StFun};
    timeout    = byte_state && !rx_d_valid && (cnt_q == CntW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge ref_clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (rx_d_valid || !byte_state) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge ref_clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    alu_path_d = alu_path_q;
    unique case (state_q)
      StIdle: begin
        if (rx_d_valid) begin
          case (rx_p_data)
            CmdWr:   state_d = StWrAddr;
            CmdRd:   state_d = StRdAddr;
            CmdAlu:  state_d = StOpA;
            CmdFun:  state_d = StFun;
            default: state_d = StIdle;
          endcase
        end
      end
      StWrAddr: if (rx_d_valid) state_d = StWrData;
      StWrData: if (rx_d_valid) state_d = StIdle;
      StRdAddr: if (rx_d_valid) state_d = StRdWait;
      StRdWait: begin
        if (rf_rd_valid) begin
          result_d   = {{DATA_W{1'b0}}, rf_rd_data};
          alu_path_d = 1'b0;
          state_d    = StTxLo;
        end
      end
      StOpA:    if (rx_d_valid) state_d = StOpB;
      StOpB:    if (rx_d_valid) state_d = StFun;
      StFun:    if (rx_d_valid) state_d = StAluWait;
      StAluWait: begin
        if (alu_out_valid) begin
          result_d   = alu_out;
          alu_path_d = 1'b1;
          state_d    = StTxLo;
        end
      end
      StTxLo:   if (!tx_full) state_d = alu_path_q ? StTxHi : StIdle;
      StTxHi:   if (!tx_full) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // A timeout only fires in a byte-waiting state with no byte present, so nothing is emitted.
    if (timeout) state_d = StIdle;
  end

  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    tx_wr_en_d   = 1'b0;
    rf_addr_d    = rf_addr;
    rf_wr_data_d = rf_wr_data;
    alu_fun_d    = alu_fun;
    tx_wr_data_d = tx_wr_data;
    // Gate opens on entry to FUN, so it always leads alu_en by at least one cycle.
    alu_clk_en_d = (state_d == StFun) || (state_d == StAluWait);
    unique case (state_q)
      StWrAddr: if (rx_d_valid) rf_addr_d = rx_p_data[ADDR_W-1:0];
      StWrData: begin
        if (rx_d_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_wr_data_d = rx_p_data;
        end
      end
      StRdAddr: begin
        if (rx_d_valid) begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = rx_p_data[ADDR_W-1:0];
        end
      end
      StOpA, StOpB: begin
        if (rx_d_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = (state_q == StOpA) ? ADDR_W'(0) : ADDR_W'(1);
          rf_wr_data_d = rx_p_data;
        end
      end
      StFun: begin
        if (rx_d_valid) begin
          alu_en_d  = 1'b1;
          alu_fun_d = rx_p_data[FUN_W-1:0];
        end
      end
      StTxLo: begin
        if (!tx_full) begin
          tx_wr_en_d   = 1'b1;
          tx_wr_data_d = result_q[DATA_W-1:0];
        end
      end
      StTxHi: begin
        if (!tx_full) begin
          tx_wr_en_d   = 1'b1;
          tx_wr_data_d = result_q[2*DATA_W-1:DATA_W];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ref_clk or negedge rst) begin
    if (!rst) begin
      result_q   <= '0;
      alu_path_q <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      alu_en     <= 1'b0;
      alu_fun    <= '0;
      alu_clk_en <= 1'b0;
      tx_wr_en   <= 1'b0;
      tx_wr_data <= '0;
    end else begin
      result_q   <= result_d;
      alu_path_q <= alu_path_d;
      rf_wr_en   <= rf_wr_en_d;
      rf_rd_en   <= rf_rd_en_d;
      rf_addr    <= rf_addr_d;
      rf_wr_data <= rf_wr_data_d;
      alu_en     <= alu_en_d;
      alu_fun    <= alu_fun_d;
      alu_clk_en <= alu_clk_en_d;
      tx_wr_en   <= tx_wr_en_d;
      tx_wr_data <= tx_wr_data_d;
    end
  end

endmodule
